// File: rtl/truth_table_bist_pkg.sv
// Shared encodings and width helpers for the exhaustive truth-table tester.
// Pure declarations; no logic, no timing.
package truth_table_bist_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_APPLY = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    function automatic int nvec_f(input int n_in);
        return 1 << n_in;
    endfunction

    function automatic int cnt_w_f(input int n_in);
        return n_in + 1;
    endfunction

    function automatic int tmr_w_f(input int settle);
        return $clog2(settle) + 1;
    endfunction

endpackage

// File: rtl/truth_table_bist_settle_timer.sv
// Settle counter: counts 0..SETTLE-1 while enabled, tick on the terminal count.
// tick is combinational from the count register; clr wins over en.
module bist_settle_timer
    import truth_table_bist_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int TW = tmr_w_f(SETTLE);
    localparam logic [TW-1:0] LAST = TW'(SETTLE - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    always_comb begin
        tick  = en && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/truth_table_bist.sv
// Exhaustive tester: walks stim 0..2^N_IN-1, holds each SETTLE cycles, compares
// dut_out to GOLDEN on the last hold cycle; start is ignored while a run is active.
module truth_table_bist
    import truth_table_bist_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int N_OUT  = 1,
    parameter int SETTLE = 1,
    parameter logic [N_OUT*(1<<N_IN)-1:0] GOLDEN = 16'h6996
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop_on_fail,
    input  logic [N_OUT-1:0]   dut_out,
    output logic [N_IN-1:0]    stim,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [N_IN:0]      err_count,
    output logic               first_fail_valid,
    output logic [N_IN-1:0]    first_fail_vec
);

    localparam int NVEC  = nvec_f(N_IN);
    localparam int CNT_W = cnt_w_f(N_IN);
    localparam logic [CNT_W-1:0] ERR_MAX = CNT_W'(NVEC);

    logic [1:0]       state_q, state_d;
    logic [N_IN-1:0]  stim_q, stim_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic             ffv_q, ffv_d;
    logic [N_IN-1:0]  ffvec_q, ffvec_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;

    logic             tick;
    logic             start_acc;
    logic             sample;
    logic             mism;
    logic             halt;
    logic [N_OUT-1:0] gold_tab [NVEC];

    for (genvar v = 0; v < NVEC; v++) begin : g_gold
        assign gold_tab[v] = GOLDEN[v*N_OUT +: N_OUT];
    end

    bist_settle_timer #(.SETTLE(SETTLE)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_acc),
        .en   (state_q == S_APPLY),
        .tick (tick)
    );

    // Case inequality so an X/Z response is counted as a miscompare.
    always_comb begin
        start_acc = start && (state_q != S_APPLY);
        sample    = (state_q == S_APPLY) && tick;
        mism      = (dut_out !== gold_tab[stim_q]);
        halt      = sample && ((stim_q == {N_IN{1'b1}}) || (mode_q && mism));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_acc) state_d = S_APPLY;
            S_APPLY: if (halt)      state_d = S_DONE;
            S_DONE:  if (start_acc) state_d = S_APPLY;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy             = (state_q == S_APPLY);
        stim             = stim_q;
        done             = done_q;
        pass             = pass_q;
        err_count        = err_q;
        first_fail_valid = ffv_q;
        first_fail_vec   = ffvec_q;
    end

    always_comb begin
        stim_d  = stim_q;
        err_d   = err_q;
        ffv_d   = ffv_q;
        ffvec_d = ffvec_q;
        mode_d  = mode_q;
        done_d  = done_q;
        pass_d  = pass_q;
        if (start_acc) begin
            stim_d  = '0;
            err_d   = '0;
            ffv_d   = 1'b0;
            ffvec_d = '0;
            mode_d  = stop_on_fail;
            done_d  = 1'b0;
            pass_d  = 1'b0;
        end else if (sample) begin
            if (mism) begin
                if (err_q != ERR_MAX) err_d = err_q + 1'b1;
                if (!ffv_q) begin
                    ffv_d   = 1'b1;
                    ffvec_d = stim_q;
                end
            end
            // stim stays on the last vector at the end so it never wraps.
            if (halt) begin
                done_d = 1'b1;
                pass_d = (err_d == '0);
            end else begin
                stim_d = stim_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stim_q  <= '0;
            err_q   <= '0;
            ffv_q   <= 1'b0;
            ffvec_q <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            stim_q  <= stim_d;
            err_q   <= err_d;
            ffv_q   <= ffv_d;
            ffvec_q <= ffvec_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

endmodule
